// File: rtl/temp_avg_drift.sv
// temp_avg_drift: periodically samples three raw ADC temperature codes and
// smooths each one through an 8-deep moving average. It also tracks drift of
// the averaged sensor code against a calibration reference, and raises a
// level calibration request that the calibration controller acknowledges.
module temp_avg_drift #(
    parameter int unsigned CLK_IN_FREQ   = 6_000_000,
    parameter int unsigned SAMPLE_CYCLES = 1_800_000,
    parameter logic [15:0] DRIFT_THRESH  = 16'd64
) (
    input  logic        i_mc,
    input  logic        i_rst_n,
    input  logic [15:0] i_temp_sensor,
    input  logic [15:0] i_temp_shutter,
    input  logic [15:0] i_temp_lens,
    input  logic        i_nuc_ack,
    output logic [15:0] o_avg_sensor,
    output logic [15:0] o_avg_shutter,
    output logic [15:0] o_avg_lens,
    output logic        o_avg_vld,
    output logic [15:0] o_drift,
    output logic        o_nuc_req
);

    localparam int unsigned CNT_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

    // A period shorter than one sampling round would let a tick land outside IDLE.
    if (SAMPLE_CYCLES < 8 || CLK_IN_FREQ == 0) begin : g_bad_params
        $error("temp_avg_drift: SAMPLE_CYCLES must be >= 8 and CLK_IN_FREQ nonzero");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_UPD0,
        S_UPD1,
        S_UPD2,
        S_CMP
    } state_e;

    // Channel index 0 = sensor, 1 = shutter, 2 = lens.
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       ptr_q, ptr_d;
    logic             primed_q, primed_d;
    logic [15:0]      smp_q  [3];
    logic [15:0]      smp_d  [3];
    logic [15:0]      hist_q [3][8];
    logic [15:0]      hist_d [3][8];
    logic [18:0]      sum_q  [3];
    logic [18:0]      sum_d  [3];
    logic [15:0]      avg_q  [3];
    logic [15:0]      avg_d  [3];
    logic [15:0]      ref_q, ref_d;
    logic [15:0]      drift_q, drift_d;
    logic             req_q, req_d;
    logic             vld_q, vld_d;

    logic             tick;
    logic             upd_en;
    logic [1:0]       ch;
    logic [18:0]      smp_ext;
    logic [18:0]      old_ext;
    logic [18:0]      new_sum;
    logic [16:0]      diff;
    logic [16:0]      diff_mag;
    logic             cmp_set;

    assign tick = (cnt_q == CNT_W'(SAMPLE_CYCLES - 1));

    // Next-state, history update, drift compare and request handshake.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
        ptr_d    = ptr_q;
        primed_d = primed_q;
        smp_d    = smp_q;
        hist_d   = hist_q;
        sum_d    = sum_q;
        avg_d    = avg_q;
        ref_d    = ref_q;
        drift_d  = drift_q;
        req_d    = req_q;
        vld_d    = 1'b0;
        upd_en   = 1'b0;
        ch       = 2'd0;
        smp_ext  = '0;
        old_ext  = '0;
        new_sum  = '0;
        cmp_set  = 1'b0;
        diff     = {avg_q[0][15], avg_q[0]} - {ref_q[15], ref_q};
        diff_mag = diff[16] ? (~diff + 17'd1) : diff;

        case (state_q)
            S_IDLE: begin
                if (tick) state_d = S_LATCH;
            end
            S_LATCH: begin
                // All three channels are captured on the same edge to keep the set coherent.
                smp_d[0] = i_temp_sensor;
                smp_d[1] = i_temp_shutter;
                smp_d[2] = i_temp_lens;
                state_d  = S_UPD0;
            end
            S_UPD0: begin
                upd_en  = 1'b1;
                ch      = 2'd0;
                state_d = S_UPD1;
            end
            S_UPD1: begin
                upd_en  = 1'b1;
                ch      = 2'd1;
                state_d = S_UPD2;
            end
            S_UPD2: begin
                upd_en  = 1'b1;
                ch      = 2'd2;
                vld_d   = 1'b1;
                state_d = S_CMP;
            end
            S_CMP: begin
                state_d = S_IDLE;
                ptr_d   = ptr_q + 3'd1;
                if (!primed_q) begin
                    primed_d = 1'b1;
                    ref_d    = avg_q[0];
                    drift_d  = '0;
                end else begin
                    if (diff[16] != diff[15]) begin
                        drift_d = diff[16] ? 16'h8000 : 16'h7FFF;
                    end else begin
                        drift_d = diff[15:0];
                    end
                    cmp_set = !req_q && (diff_mag >= {1'b0, DRIFT_THRESH});
                    if (cmp_set) req_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // One shared datapath updates whichever channel the current UPD state selects.
        if (upd_en) begin
            smp_ext = {{3{smp_q[ch][15]}}, smp_q[ch]};
            old_ext = {{3{hist_q[ch][ptr_q][15]}}, hist_q[ch][ptr_q]};
            if (!primed_q) begin
                // The first sample fills the whole window, so the first average equals the raw input.
                new_sum = {smp_q[ch], 3'b000};
                for (int i = 0; i < 8; i++) hist_d[ch][i] = smp_q[ch];
            end else begin
                new_sum = sum_q[ch] + smp_ext - old_ext;
                hist_d[ch][ptr_q] = smp_q[ch];
            end
            sum_d[ch] = new_sum;
            avg_d[ch] = new_sum[18:3];
        end

        // Calibration done: the ack wins over a same-cycle request and re-bases the reference.
        if (i_nuc_ack && (req_q || cmp_set)) begin
            req_d   = 1'b0;
            ref_d   = avg_q[0];
            drift_d = '0;
        end
    end

    // State register; every flop, including the averaging history, is cleared by reset.
    always_ff @(posedge i_mc or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ptr_q    <= '0;
            primed_q <= 1'b0;
            smp_q    <= '{default: '0};
            // NOTE: the history array is reset as well, so a reset in the middle of a round leaves no stale window.
            hist_q   <= '{default: '0};
            sum_q    <= '{default: '0};
            avg_q    <= '{default: '0};
            ref_q    <= '0;
            drift_q  <= '0;
            req_q    <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here, so every flop samples the values from before this edge.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            primed_q <= primed_d;
            smp_q    <= smp_d;
            hist_q   <= hist_d;
            sum_q    <= sum_d;
            avg_q    <= avg_d;
            ref_q    <= ref_d;
            drift_q  <= drift_d;
            req_q    <= req_d;
            vld_q    <= vld_d;
        end
    end

    assign o_avg_sensor  = avg_q[0];
    assign o_avg_shutter = avg_q[1];
    assign o_avg_lens    = avg_q[2];
    assign o_avg_vld     = vld_q;
    assign o_drift       = drift_q;
    assign o_nuc_req     = req_q;

endmodule
